// File: rtl/mips_seq_ctrl.sv
// Multi-cycle fetch/decode/exec/writeback sequencer for the Mini-MIPS datapath.
// Owns the instruction register, program counter, retired counter and error status.
module mips_seq_ctrl #(
    parameter int PC_W          = 16,
    parameter int RESET_PC      = 0,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     ir,
    input  logic [31:0]     alu_result,
    input  logic            rt_nz,
    output logic            rb_we,
    output logic [3:0]      rb_wa,
    output logic            rb_wsel,
    output logic [31:0]     wb_data,
    output logic [PC_W-1:0] pc,
    output logic [31:0]     retired,
    output logic            busy,
    output logic            halted,
    output logic [1:0]      err
);

    localparam int              CNT_W   = (FETCH_TIMEOUT < 2) ? 1 : $clog2(FETCH_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO     = CNT_W'(FETCH_TIMEOUT);
    localparam logic [PC_W-1:0]  PC_INIT = PC_W'(RESET_PC);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WB, S_HALT, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [31:0]       retired_q, retired_d;
    logic [1:0]        err_q, err_d;
    logic [31:0]       ir_q, ir_d;
    logic [3:0]        rb_wa_q, rb_wa_d;
    logic              rb_wsel_q, rb_wsel_d;
    logic              wr_q, wr_d;
    logic              cmov_q, cmov_d;
    logic              rt_nz_q, rt_nz_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

    logic [5:0] opcode, funct;
    logic [3:0] f_rs, f_rt, f_rd;
    logic       dec_write, dec_wsel, dec_cmov, dec_halt, dec_illegal;
    logic [3:0] dec_wa;

    assign opcode = ir_q[31:26];
    assign f_rs   = ir_q[25:22];
    assign f_rt   = ir_q[21:18];
    assign f_rd   = ir_q[17:14];
    assign funct  = ir_q[8:3];

    always_comb begin
        dec_write   = 1'b0;
        dec_wa      = 4'd0;
        dec_wsel    = 1'b0;
        dec_cmov    = 1'b0;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        if (opcode == 6'b000000) begin
            if (funct inside {[6'd8:6'd13], [6'd16:6'd20], 6'd25, 6'd26, 6'd27, 6'd40}) begin
                dec_write = 1'b1;
                dec_wa    = f_rd;
            end else if (funct == 6'b110000 || funct == 6'b110001) begin
                // MOV/CMOV write the rt operand back into rs
                dec_write = 1'b1;
                dec_wa    = f_rs;
                dec_wsel  = 1'b1;
                dec_cmov  = funct[0];
            end else begin
                dec_illegal = 1'b1;
            end
        end else if (opcode inside {6'd8, 6'd9, 6'd16, 6'd17, 6'd18, 6'd24, 6'd25, 6'd26, 6'd48}) begin
            dec_write = 1'b1;
            dec_wa    = f_rt;
        end else if (opcode == 6'b111111) begin
            dec_halt = 1'b1;
        end else begin
            dec_illegal = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        retired_d  = retired_q;
        err_d      = err_q;
        ir_d       = ir_q;
        rb_wa_d    = rb_wa_q;
        rb_wsel_d  = rb_wsel_q;
        wr_d       = wr_q;
        cmov_d     = cmov_q;
        rt_nz_d    = rt_nz_q;
        wb_data_d  = wb_data_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    pc_d       = PC_INIT;
                    retired_d  = 32'd0;
                    err_d      = 2'd0;
                    wait_cnt_d = '0;
                    state_d    = S_FETCH;
                end
            end
            S_FETCH: begin
                // valid on the cycle the counter hits the limit still wins
                if (imem_valid) begin
                    ir_d       = imem_rdata;
                    wait_cnt_d = '0;
                    state_d    = S_DECODE;
                end else if (wait_cnt_q >= TMO) begin
                    err_d      = 2'd2;
                    wait_cnt_d = '0;
                    state_d    = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                if (dec_illegal) begin
                    err_d   = 2'd1;
                    state_d = S_ERR;
                end else if (dec_halt) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = S_HALT;
                end else begin
                    rb_wa_d   = dec_wa;
                    rb_wsel_d = dec_wsel;
                    wr_d      = dec_write;
                    cmov_d    = dec_cmov;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                wb_data_d = alu_result;
                rt_nz_d   = rt_nz;
                state_d   = S_WB;
            end
            S_WB: begin
                pc_d      = pc_q + PC_W'(1);
                retired_d = retired_q + 32'd1;
                state_d   = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            pc_q       <= PC_INIT;
            retired_q  <= 32'd0;
            err_q      <= 2'd0;
            ir_q       <= 32'd0;
            rb_wa_q    <= 4'd0;
            rb_wsel_q  <= 1'b0;
            wr_q       <= 1'b0;
            cmov_q     <= 1'b0;
            rt_nz_q    <= 1'b0;
            wb_data_q  <= 32'd0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            retired_q  <= retired_d;
            err_q      <= err_d;
            ir_q       <= ir_d;
            rb_wa_q    <= rb_wa_d;
            rb_wsel_q  <= rb_wsel_d;
            wr_q       <= wr_d;
            cmov_q     <= cmov_d;
            rt_nz_q    <= rt_nz_d;
            wb_data_q  <= wb_data_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Strobe decoded from flops so an asynchronous reset kills it at once
    assign rb_we     = (state_q == S_WB) && wr_q && (!cmov_q || rt_nz_q);
    assign imem_req  = (state_q == S_FETCH);
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign rb_wa     = rb_wa_q;
    assign rb_wsel   = rb_wsel_q;
    assign wb_data   = wb_data_q;
    assign retired   = retired_q;
    assign err       = err_q;
    assign busy      = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                       (state_q == S_EXEC)  || (state_q == S_WB);
    assign halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_mips_seq_ctrl.sv
// Directed bench for mips_seq_ctrl: an instruction-memory responder feeds programs,
// and a monitor checks every write strobe against a queue of expected writes.
module tb_mips_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] ir;
    logic [31:0] alu_result;
    logic        rt_nz;
    logic        rb_we;
    logic [3:0]  rb_wa;
    logic        rb_wsel;
    logic [31:0] wb_data;
    logic [15:0] pc;
    logic [31:0] retired;
    logic        busy;
    logic        halted;
    logic [1:0]  err_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem      [16];
    logic [31:0] alu_mem  [16];
    logic        rtnz_mem [16];
    int          fetch_delay = 0;
    int          wait_seen = 0;

    typedef struct {
        logic [3:0]  wa;
        logic        wsel;
        logic [31:0] data;
        logic [15:0] pc;
        logic [31:0] retired;
    } wr_t;
    wr_t exp_q[$];

    mips_seq_ctrl #(.PC_W(16), .RESET_PC(0), .FETCH_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .ir(ir), .alu_result(alu_result), .rt_nz(rt_nz),
        .rb_we(rb_we), .rb_wa(rb_wa), .rb_wsel(rb_wsel),
        .wb_data(wb_data), .pc(pc), .retired(retired),
        .busy(busy), .halted(halted), .err(err_o)
    );

    always #5 clk = ~clk;

    assign alu_result = alu_mem[pc[3:0]];
    assign rt_nz      = rtnz_mem[pc[3:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] r_ins(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 4'(rs), 4'(rt), 4'(rd), 5'd0, 6'(fn), 3'd0};
    endfunction

    function automatic logic [31:0] i_ins(input int op, input int rs, input int rt);
        return {6'(op), 4'(rs), 4'(rt), 18'h002A5};
    endfunction

    function automatic wr_t mk(input int wa, input int wsel, input logic [31:0] d,
                               input int p, input int r);
        wr_t w;
        w.wa = 4'(wa); w.wsel = 1'(wsel); w.data = d; w.pc = 16'(p); w.retired = 32'(r);
        return w;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'hFFFF_FFFF;     // HALT everywhere by default
            alu_mem[i] = 32'h0BAD_0000 + 32'(i);
            rtnz_mem[i] = 1'b0;
        end
    endtask

    // Instruction memory: answers a request after fetch_delay wait cycles
    always @(negedge clk) begin
        if (imem_req) begin
            if (wait_seen == fetch_delay) begin
                imem_valid = 1'b1;
                imem_rdata = mem[imem_addr[3:0]];
                wait_seen  = 0;
            end else begin
                imem_valid = 1'b0;
                wait_seen++;
            end
        end else begin
            imem_valid = 1'b0;
            imem_rdata = 32'hA5A5_A5A5;
            wait_seen  = 0;
        end
    end

    // Scoreboard monitor: every write strobe must match the oldest expectation
    always @(negedge clk) begin
        if (rst && rb_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rb_we", {28'd0, rb_wa}, 32'hFFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                $display("write: wa=%0d wsel=%0d data=0x%08h pc=%0d retired=%0d",
                         rb_wa, rb_wsel, wb_data, pc, retired);
                check("wr_wa", {28'd0, rb_wa}, {28'd0, w.wa});
                check("wr_wsel", {31'd0, rb_wsel}, {31'd0, w.wsel});
                check("wr_data", wb_data, w.data);
                check("wr_pc", {16'd0, pc}, {16'd0, w.pc});
                check("wr_retired", retired, w.retired);
            end
        end
    end

    // Returns at the first FETCH negedge after start is sampled
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy) check({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        clear_prog();
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_imem_req", {31'd0, imem_req}, 32'd0);
        check("rst_pc", {16'd0, pc}, 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_err", {30'd0, err_o}, 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_req", {31'd0, imem_req}, 32'd0);

        // ADD then HALT, zero-wait fetch
        clear_prog();
        mem[0] = r_ins(1, 2, 5, 6'b001000);
        alu_mem[0] = 32'h0000_0007;
        exp_q.push_back(mk(5, 0, 32'h7, 0, 0));
        pulse_start();
        for (int c = 1; c <= 4; c++) begin
            if (c > 1) @(negedge clk);
            check($sformatf("add_we_cycle%0d", c), {31'd0, rb_we}, (c == 4) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        check("add_pc_after", {16'd0, pc}, 32'd1);
        check("add_retired_after", retired, 32'd1);
        check("add_imem_addr", {16'd0, imem_addr}, 32'd1);
        wait_idle("add");
        check("add_halted", {31'd0, halted}, 32'd1);
        check("add_retired_halt", retired, 32'd2);
        $display("txn add+halt: pc=%0d retired=%0d halted=%0d", pc, retired, halted);

        // I-type ADDI then HALT
        clear_prog();
        mem[0] = i_ins(6'b001000, 1, 3);
        alu_mem[0] = 32'hDEAD_BEEF;
        exp_q.push_back(mk(3, 0, 32'hDEAD_BEEF, 0, 0));
        pulse_start();
        wait_idle("itype");
        check("itype_halted", {31'd0, halted}, 32'd1);
        check("itype_retired", retired, 32'd2);
        check("itype_pc", {16'd0, pc}, 32'd1);
        repeat (3) @(negedge clk);
        check("itype_no_req", {31'd0, imem_req}, 32'd0);
        $display("txn itype+halt: pc=%0d retired=%0d", pc, retired);

        // CMOV not taken, CMOV taken, MOV with rt_nz=0, HALT
        clear_prog();
        mem[0] = r_ins(2, 4, 0, 6'b110001);
        mem[1] = r_ins(2, 4, 0, 6'b110001);
        mem[2] = r_ins(9, 6, 0, 6'b110000);
        rtnz_mem[1] = 1'b1;
        alu_mem[1] = 32'h0000_0055;
        alu_mem[2] = 32'h0000_0066;
        exp_q.push_back(mk(2, 1, 32'h55, 1, 1));
        exp_q.push_back(mk(9, 1, 32'h66, 2, 2));
        pulse_start();
        wait_idle("cmov");
        check("cmov_retired", retired, 32'd4);
        check("cmov_pc", {16'd0, pc}, 32'd3);
        $display("txn cmov/mov: pc=%0d retired=%0d", pc, retired);

        // R-type then illegal opcode 000101
        clear_prog();
        mem[0] = r_ins(3, 5, 1, 6'b011011);
        mem[1] = i_ins(6'b000101, 1, 1);
        alu_mem[0] = 32'h0000_0011;
        exp_q.push_back(mk(1, 0, 32'h11, 0, 0));
        pulse_start();
        wait_idle("illegal");
        check("illegal_err", {30'd0, err_o}, 32'd1);
        check("illegal_pc", {16'd0, pc}, 32'd1);
        check("illegal_retired", retired, 32'd1);
        check("illegal_not_halted", {31'd0, halted}, 32'd0);
        $display("txn illegal: err=%0d pc=%0d", err_o, pc);

        // Restart from ERR with memory withheld -> timeout
        fetch_delay = 1000;
        pulse_start();
        check("restart_err_clear", {30'd0, err_o}, 32'd0);
        check("restart_pc", {16'd0, pc}, 32'd0);
        check("restart_retired", retired, 32'd0);
        check("restart_fetch", {31'd0, imem_req}, 32'd1);
        n = 1;
        while (err_o == 2'd0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycle", 32'(n), 32'd6);
        check("timeout_err", {30'd0, err_o}, 32'd2);
        check("timeout_idle", {31'd0, busy}, 32'd0);
        $display("txn timeout: err=%0d after %0d fetch cycles", err_o, n - 1);

        // Valid arriving exactly when the wait counter hits the limit
        clear_prog();
        fetch_delay = 4;
        mem[0] = i_ins(6'b011010, 0, 7);
        alu_mem[0] = 32'h1234_5678;
        exp_q.push_back(mk(7, 0, 32'h1234_5678, 0, 0));
        pulse_start();
        wait_idle("late_valid");
        check("late_valid_err", {30'd0, err_o}, 32'd0);
        check("late_valid_halted", {31'd0, halted}, 32'd1);
        check("late_valid_retired", retired, 32'd2);
        $display("txn late valid: err=%0d retired=%0d", err_o, retired);

        // Asynchronous reset in the middle of WB
        clear_prog();
        fetch_delay = 0;
        mem[0] = r_ins(0, 0, 10, 6'b101000);
        alu_mem[0] = 32'h0000_00AA;
        exp_q.push_back(mk(10, 0, 32'hAA, 0, 0));
        pulse_start();
        repeat (3) @(negedge clk);
        check("wb_before_rst", {31'd0, rb_we}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("rst_wb_we", {31'd0, rb_we}, 32'd0);
        check("rst_wb_busy", {31'd0, busy}, 32'd0);
        check("rst_wb_wa", {28'd0, rb_wa}, 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_ir", ir, 32'd0);
        check("rst_wb_retired", retired, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_stays_idle", {31'd0, imem_req}, 32'd0);
        exp_q.push_back(mk(10, 0, 32'hAA, 0, 0));
        pulse_start();
        wait_idle("resume");
        check("resume_retired", retired, 32'd2);
        $display("txn reset-in-wb: resumed, retired=%0d", retired);

        repeat (2) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
